// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} clk_div_state_t;

  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_FW  = 32;

  // ceil(div/2), one bit wider than the operand so an all-ones divisor cannot wrap
  function automatic logic [CLK_DIV_FW:0] clk_div_hi(input logic [CLK_DIV_FW-1:0] div);
    return ({1'b0, div} + {{CLK_DIV_FW{1'b0}}, 1'b1}) >> 1;
  endfunction
endpackage

// File: rtl/clk_div_core.sv
// Divide-by-N counter with registered oclk/tick; divisor swaps only via load.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             act_nxt,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] cur_div,
  output logic             oclk,
  output logic             tick,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             act;
  logic [WIDTH-1:0] cnt, cnt_nxt, div_nxt;
  logic [WIDTH:0]   hi;

  always_comb begin
    wrap    = act && (cnt == cur_div - ONE);
    div_nxt = load ? div_in : cur_div;
    cnt_nxt = (!act || wrap) ? '0 : cnt + ONE;
    hi      = (WIDTH+1)'(clk_div_hi(CLK_DIV_FW'(div_nxt)));
  end

  // outputs are computed from the post-edge count so oclk rises on the start edge
  always_ff @(posedge iclk) begin
    if (!rst) begin
      act     <= 1'b0;
      cnt     <= '0;
      oclk    <= 1'b0;
      tick    <= 1'b0;
      cur_div <= WIDTH'(DEFAULT_DIV);
    end else begin
      cur_div <= div_nxt;
      act     <= act_nxt;
      if (act_nxt) begin
        cnt  <= cnt_nxt;
        oclk <= ({1'b0, cnt_nxt} < hi);
        tick <= (cnt_nxt == div_nxt - ONE);
      end else begin
        cnt  <= '0;
        oclk <= 1'b0;
        tick <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop sequencing and divisor handshake; changes land only on period wraps.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             oclk,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             err
);
  clk_div_state_t   state, state_nxt;
  logic [WIDTH-1:0] pend_div, div_in;
  logic             hs, div_ok, load, act_nxt, pend_ld, wrap;

  assign cfg_ready = (state != PEND);
  assign hs        = cfg_valid && cfg_ready;
  assign div_ok    = (cfg_div >= WIDTH'(CLK_DIV_MIN));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    div_in    = cfg_div;
    act_nxt   = (state != IDLE);
    pend_ld   = 1'b0;
    case (state)
      IDLE: begin
        load      = hs && div_ok;
        act_nxt   = en;
        state_nxt = en ? RUN : IDLE;
      end
      RUN: begin
        if (wrap) begin
          // a divisor arriving on the wrap edge skips PEND entirely
          load      = hs && div_ok;
          act_nxt   = en;
          state_nxt = en ? RUN : IDLE;
        end else if (hs && div_ok) begin
          pend_ld   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          load      = 1'b1;
          div_in    = pend_div;
          act_nxt   = en;
          state_nxt = en ? RUN : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        act_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!rst) begin
      state    <= IDLE;
      pend_div <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pend_ld) pend_div <= cfg_div;
      err   <= hs && !div_ok;
      busy  <= (state_nxt != IDLE);
    end
  end

  clk_div_core #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_core (
    .iclk    (iclk),
    .rst     (rst),
    .act_nxt (act_nxt),
    .load    (load),
    .div_in  (div_in),
    .cur_div (cur_div),
    .oclk    (oclk),
    .tick    (tick),
    .wrap    (wrap)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed vectors for clk_div_ctrl with a queue-based scoreboard and negedge monitor.
module tb_clk_div_ctrl;
  logic       iclk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, oclk, tick, busy, err;
  logic [7:0] cur_div;

  typedef struct packed {
    logic       oclk, tick, busy;
    logic [7:0] cur;
    logic       rdy, err;
  } obs_t;
  typedef struct packed {
    int   id;
    obs_t o;
  } ent_t;

  ent_t q[$];
  int   compared = 0, mismatched = 0, nstep = 0;

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .iclk(iclk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .oclk(oclk), .tick(tick), .busy(busy),
    .cur_div(cur_div), .err(err)
  );

  always #5 iclk = ~iclk;

  // one edge: drive inputs, then queue the outputs required after that edge
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d,
                      input logic o, input logic t, input logic b, input logic [7:0] c,
                      input logic rd, input logic er);
    ent_t x;
    rst = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge iclk);
    x.id = nstep; x.o = '{o, t, b, c, rd, er};
    q.push_back(x);
    nstep++;
    #1;
  endtask

  always @(negedge iclk) begin
    if (q.size() > 0) begin
      ent_t x;
      obs_t a;
      x = q.pop_front();
      a = '{oclk, tick, busy, cur_div, cfg_ready, err};
      compared++;
      if (a !== x.o) begin
        mismatched++;
        $display("FAIL step%0d got oclk=%b tick=%b busy=%b cur=%0d rdy=%b err=%b exp oclk=%b tick=%b busy=%b cur=%0d rdy=%b err=%b",
                 x.id, a.oclk, a.tick, a.busy, a.cur, a.rdy, a.err,
                 x.o.oclk, x.o.tick, x.o.busy, x.o.cur, x.o.rdy, x.o.err);
      end
    end
  end

  initial begin
    //   rst en v  div   o t b cur rdy err
    step(0, 0, 0, 0,     0,0,0, 3, 1,0);
    step(0, 1, 1, 7,     0,0,0, 3, 1,0);   // handshake in reset ignored
    step(1, 0, 0, 0,     0,0,0, 3, 1,0);
    // N=3 run: 1,1,0
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     0,1,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     0,1,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);   // count 0
    // write 4 at count 0 -> PEND for two cycles
    step(1, 1, 1, 4,     1,0,1, 3, 0,0);
    step(1, 1, 0, 0,     0,1,1, 3, 0,0);
    step(1, 1, 0, 0,     1,0,1, 4, 1,0);
    step(1, 1, 0, 0,     1,0,1, 4, 1,0);
    step(1, 1, 0, 0,     0,0,1, 4, 1,0);
    step(1, 1, 0, 0,     0,1,1, 4, 1,0);
    // write 5 on the wrap edge -> immediate, no PEND
    step(1, 1, 1, 5,     1,0,1, 5, 1,0);
    step(1, 1, 0, 0,     1,0,1, 5, 1,0);
    step(1, 1, 0, 0,     1,0,1, 5, 1,0);
    step(1, 1, 0, 0,     0,0,1, 5, 1,0);
    step(1, 1, 0, 0,     0,1,1, 5, 1,0);
    step(1, 1, 0, 0,     1,0,1, 5, 1,0);
    // rejected divisors 1 and 0
    step(1, 1, 1, 1,     1,0,1, 5, 1,1);
    step(1, 1, 0, 0,     1,0,1, 5, 1,0);
    step(1, 1, 1, 0,     0,0,1, 5, 1,1);
    step(1, 1, 0, 0,     0,1,1, 5, 1,0);
    // write 4 on the wrap, then drop en at count 0
    step(1, 1, 1, 4,     1,0,1, 4, 1,0);
    step(1, 0, 0, 0,     1,0,1, 4, 1,0);
    step(1, 0, 0, 0,     0,0,1, 4, 1,0);
    step(1, 0, 0, 0,     0,1,1, 4, 1,0);
    step(1, 0, 0, 0,     0,0,0, 4, 1,0);
    step(1, 0, 0, 0,     0,0,0, 4, 1,0);
    step(1, 1, 0, 0,     1,0,1, 4, 1,0);   // restart on sampling edge
    step(1, 1, 0, 0,     1,0,1, 4, 1,0);
    // pend 6 then reset mid-PEND
    step(1, 1, 1, 6,     0,0,1, 4, 0,0);
    step(0, 1, 0, 0,     0,0,0, 3, 1,0);
    step(1, 0, 0, 0,     0,0,0, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);
    step(1, 1, 0, 0,     0,1,1, 3, 1,0);
    step(1, 1, 0, 0,     1,0,1, 3, 1,0);   // 6 never applied
    // stop, load in IDLE, then en + divisor together
    step(1, 0, 0, 0,     1,0,1, 3, 1,0);
    step(1, 0, 0, 0,     0,1,1, 3, 1,0);
    step(1, 0, 0, 0,     0,0,0, 3, 1,0);
    step(1, 0, 1, 2,     0,0,0, 2, 1,0);
    step(1, 1, 1, 6,     1,0,1, 6, 1,0);
    step(1, 1, 0, 0,     1,0,1, 6, 1,0);
    step(1, 1, 0, 0,     1,0,1, 6, 1,0);
    step(1, 1, 0, 0,     0,0,1, 6, 1,0);
    step(1, 1, 0, 0,     0,0,1, 6, 1,0);
    step(1, 1, 0, 0,     0,1,1, 6, 1,0);
    step(1, 1, 0, 0,     1,0,1, 6, 1,0);
    @(negedge iclk);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain got %0d pending entries exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
